// File: rtl/instr_fetch_unit.sv
// Instruction fetch and step controller feeding the MCP core.
// Holds a loadable program memory and presents the registered word at the
// MCP's next_address. It issues one-cycle execute strobes, either from a
// debounced single-step button or continuously in run mode.
module instr_fetch_unit #(
  parameter int DEPTH      = 32,
  parameter int DEB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       prog_we,
  input  logic [7:0] prog_addr,
  input  logic [7:0] prog_data,
  input  logic       step_btn,
  input  logic       run_mode,
  input  logic [7:0] next_address,
  output logic [7:0] instruction,
  output logic       cpu_step,
  output logic       halted,
  output logic       busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  // 9 bits so that a DEPTH of 256 still compares correctly against 8-bit addresses
  localparam logic [8:0]    DEPTH_LIM = 9'(DEPTH);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_SETTLE = 3'd2,
    S_ISSUE  = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t        state_reg;
  state_t        state_next;
  logic          sync_meta_reg;
  logic          sync_reg;
  logic          deb_level_reg;
  logic          deb_prev_reg;
  logic [CW-1:0] deb_cnt_reg;
  logic          step_req_reg;
  logic [7:0]    instr_reg;
  logic          halted_reg;
  logic [7:0]    mem [DEPTH];

  logic          fetch_ok;
  logic          write_ok;
  logic          take_step;
  logic          deb_rise;
  logic [AW-1:0] fetch_idx;
  logic [AW-1:0] write_idx;

  // The range checks use the full address, so out-of-range values can never alias onto low words.
  assign fetch_ok  = ({1'b0, next_address} < DEPTH_LIM);
  assign write_ok  = (state_reg == S_IDLE) && prog_we && ({1'b0, prog_addr} < DEPTH_LIM);
  assign take_step = (state_reg == S_IDLE) && (run_mode || step_req_reg);
  assign deb_rise  = deb_level_reg & ~deb_prev_reg;
  assign fetch_idx = next_address[AW-1:0];
  assign write_idx = prog_addr[AW-1:0];

  // Two-flop synchroniser for the asynchronous button
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta_reg <= 1'b0;
      sync_reg      <= 1'b0;
    end else begin
      sync_meta_reg <= step_btn;
      sync_reg      <= sync_meta_reg;
    end
  end

  // Debounce: flip the level on the DEB_CYCLES-th consecutive cycle at the new value
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_level_reg <= 1'b0;
      deb_prev_reg  <= 1'b0;
      deb_cnt_reg   <= '0;
    end else begin
      deb_prev_reg <= deb_level_reg;
      if (sync_reg != deb_level_reg) begin
        if (deb_cnt_reg == DEB_LAST) begin
          deb_level_reg <= sync_reg;
          deb_cnt_reg   <= '0;
        end else begin
          deb_cnt_reg <= deb_cnt_reg + 1'b1;
        end
      end else begin
        deb_cnt_reg <= '0;
      end
    end
  end

  // Pending step flag: consumed on entry to ISSUE, discarded in HALT; extra edges are dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      step_req_reg <= 1'b0;
    end else if (state_reg == S_HALT) begin
      step_req_reg <= 1'b0;
    end else if (take_step) begin
      step_req_reg <= 1'b0;
    end else if (deb_rise) begin
      step_req_reg <= 1'b1;
    end
  end

  // Program memory write port; contents intentionally survive reset
  always_ff @(posedge clk) begin
    if (write_ok) begin
      mem[write_idx] <= prog_data;
    end
  end

  // Registered instruction read and the sticky out-of-range flag
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_reg  <= 8'h00;
      halted_reg <= 1'b0;
    end else if (state_reg == S_FETCH) begin
      if (fetch_ok) begin
        instr_reg <= mem[fetch_idx];
      end else begin
        instr_reg  <= 8'h00;
        halted_reg <= 1'b1;
      end
    end
  end

  // FSM state register; reset restarts at FETCH to re-read the current address
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:  state_next = fetch_ok ? S_SETTLE : S_HALT;
      S_SETTLE: state_next = S_IDLE;
      S_IDLE:   state_next = take_step ? S_ISSUE : S_IDLE;
      S_ISSUE:  state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_FETCH;
    endcase
  end

  // FSM outputs: the strobe exists only in ISSUE, so strobes are at least 4 cycles apart
  always_comb begin
    cpu_step = (state_reg == S_ISSUE);
    busy     = (state_reg != S_IDLE);
  end

  assign instruction = instr_reg;
  assign halted      = halted_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit with a small MCP model that
// advances next_address whenever it sees cpu_step.
module tb_instr_fetch_unit;

  logic       clk;
  logic       reset;
  logic       prog_we;
  logic [7:0] prog_addr;
  logic [7:0] prog_data;
  logic       step_btn;
  logic       run_mode;
  logic [7:0] next_address;
  logic [7:0] instruction;
  logic       cpu_step;
  logic       halted;
  logic       busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int last_strobe_cyc = 0;
  bit mcp_auto = 0;
  bit mcp_jump = 0;

  instr_fetch_unit #(.DEPTH(32), .DEB_CYCLES(4)) dut (
    .clk(clk),
    .reset(reset),
    .prog_we(prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .step_btn(step_btn),
    .run_mode(run_mode),
    .next_address(next_address),
    .instruction(instruction),
    .cpu_step(cpu_step),
    .halted(halted),
    .busy(busy)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // MCP model: count strobes and advance the fetch address at the end of ISSUE
  initial forever begin
    @(negedge clk);
    if (cpu_step === 1'b1) begin
      strobe_cnt = strobe_cnt + 1;
      last_strobe_cyc = cyc;
      if (mcp_auto) next_address = mcp_jump ? 8'd40 : next_address + 8'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic do_reset(input logic [7:0] addr);
    @(negedge clk);
    reset = 1;
    next_address = addr;
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  task automatic press(input int hold);
    int start;
    start = cyc;
    step_btn = 1;
    repeat (hold) @(negedge clk);
    step_btn = 0;
    repeat (20) @(negedge clk);
  endtask

  task automatic wait_strobe(output bit found);
    found = 0;
    for (int t = 0; t < 16 && !found; t++) begin
      @(negedge clk);
      if (cpu_step === 1'b1) found = 1;
    end
  endtask

  logic [7:0] prog [4] = '{8'h45, 8'h84, 8'h58, 8'h27};

  initial begin
    bit found;
    int prev;
    int cnt_snap;
    int t0;
    reset = 1; prog_we = 0; prog_addr = 0; prog_data = 0;
    step_btn = 0; run_mode = 0; next_address = 0;

    // Reset state while reset is held
    repeat (2) @(negedge clk);
    check("rst_instr", 32'(instruction), 32'h00);
    check("rst_step", 32'(cpu_step), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_busy", 32'(busy), 1);
    reset = 0;
    repeat (3) @(negedge clk);
    check("idle_busy", 32'(busy), 0);

    // Load program in IDLE, plus an out-of-range write that must not alias to word 0
    for (int i = 0; i < 4; i++) begin
      prog_we = 1; prog_addr = 8'(i); prog_data = prog[i];
      @(negedge clk);
    end
    prog_addr = 8'd32; prog_data = 8'hFF;
    @(negedge clk);
    prog_we = 0;
    strobe_cnt = 0;
    do_reset(8'd0);
    repeat (2) @(negedge clk);
    check("load_instr0", 32'(instruction), 32'h45);
    check("load_busy", 32'(busy), 0);
    check("load_nostep", 32'(strobe_cnt), 0);

    // Single step
    mcp_auto = 1;
    strobe_cnt = 0;
    t0 = cyc;
    press(10);
    check("step_count", 32'(strobe_cnt), 1);
    check("step_latency_ok", 32'((last_strobe_cyc - t0) <= 12), 1);
    check("step_instr", 32'(instruction), 32'h84);
    check("step_busy", 32'(busy), 0);

    // A glitch shorter than the debounce window is rejected
    strobe_cnt = 0;
    press(3);
    check("glitch_count", 32'(strobe_cnt), 0);

    // Bounce then hold high
    strobe_cnt = 0;
    step_btn = 1; @(negedge clk);
    step_btn = 0; @(negedge clk);
    step_btn = 1; @(negedge clk);
    press(10);
    check("bounce_count", 32'(strobe_cnt), 1);
    check("bounce_instr", 32'(instruction), 32'h58);

    // Run mode from a fresh fetch at address 0
    run_mode = 1;
    do_reset(8'd0);
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_strobe(found);
      check("run_found", 32'(found), 1);
      check("run_instr", 32'(instruction), 32'(prog[k]));
      if (k > 0) check("run_gap", 32'(cyc - prev), 4);
      prev = cyc;
    end
    run_mode = 0;
    cnt_snap = strobe_cnt;
    repeat (12) @(negedge clk);
    check("run_stop_count", 32'(strobe_cnt - cnt_snap), 0);
    check("run_stop_busy", 32'(busy), 0);

    // Write attempted during SETTLE is ignored
    mcp_auto = 0;
    do_reset(8'd2);
    repeat (3) @(negedge clk);
    step_btn = 1;
    wait_strobe(found);
    check("busy_wr_strobe", 32'(found), 1);
    @(negedge clk);
    @(negedge clk);
    check("settle_busy", 32'(busy), 1);
    prog_we = 1; prog_addr = 8'd2; prog_data = 8'hAA;
    @(negedge clk);
    prog_we = 0;
    check("settle_instr", 32'(instruction), 32'h58);
    step_btn = 0;
    repeat (20) @(negedge clk);
    do_reset(8'd2);
    repeat (2) @(negedge clk);
    check("refetch_instr", 32'(instruction), 32'h58);

    // Out-of-range fetch after a step
    mcp_auto = 1; mcp_jump = 1;
    strobe_cnt = 0;
    press(10);
    check("oor_count", 32'(strobe_cnt), 1);
    check("oor_instr", 32'(instruction), 32'h00);
    check("oor_halted", 32'(halted), 1);
    check("oor_busy", 32'(busy), 1);
    strobe_cnt = 0;
    press(10);
    check("halt_nostep", 32'(strobe_cnt), 0);
    check("halt_sticky", 32'(halted), 1);
    mcp_auto = 0; mcp_jump = 0;

    // Reset clears halted
    do_reset(8'd0);
    repeat (2) @(negedge clk);
    check("clr_halted", 32'(halted), 0);
    check("clr_instr", 32'(instruction), 32'h45);

    // Boundary: address DEPTH is out of range, DEPTH-related last loaded word is fine
    do_reset(8'd32);
    repeat (2) @(negedge clk);
    check("edge32_halted", 32'(halted), 1);
    check("edge32_instr", 32'(instruction), 32'h00);
    do_reset(8'd3);
    repeat (2) @(negedge clk);
    check("addr3_halted", 32'(halted), 0);
    check("addr3_instr", 32'(instruction), 32'h27);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
